ifu_prefetch: RTL and testbench

- Instruction fetch unit. Generates the sequential fetch PC, issues word reads on the instruction bus, and buffers returned instructions in a small in-order prefetch FIFO.
- Presents {inst, inst_addr} pairs to the IF/ID pipeline register, which feeds the decoder.
- Handles redirects from ex (jump) by flushing the FIFO and discarding in-flight responses.

---
 rtl/ifu_prefetch_if.sv | 29 ++
 rtl/ifu_prefetch.sv | 129 ++++++++++++
 tb/tb_ifu_prefetch.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: redirect, instruction-bus and IF/ID signals of the fetch unit.
// master = fetch unit side, slave = bus/pipeline side.
interface ifu_prefetch_if;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        inst_ready_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    modport master (
        input  jump_flag_i, jump_addr_i, inst_ready_i,
        input  ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
        output ibus_req_o, ibus_addr_o,
        output inst_valid_o, inst_o, inst_addr_o
    );

    modport slave (
        output jump_flag_i, jump_addr_i, inst_ready_i,
        output ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
        input  ibus_req_o, ibus_addr_o,
        input  inst_valid_o, inst_o, inst_addr_o
    );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential fetch PC, ibus read issue and in-order prefetch FIFO.
// Optional IFU_BYPASS_EN: an empty-FIFO response is presented the cycle it arrives.
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input logic            clk,
    input logic            rst,
    ifu_prefetch_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] CAP = (CW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outst;
    logic [CW-1:0] discard;
    logic [CW-1:0] cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] t_rd;
    logic [PW-1:0] t_wr;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   addr_q [FIFO_DEPTH];
    logic [31:0]   tag_q  [FIFO_DEPTH];

    logic          jump;
    logic          req;
    logic          gnt;
    logic          rv;
    logic          keep;
    logic          head_vld;
    logic          valid;
    logic          push;
    logic          pop;
    logic [31:0]   inst;
    logic [31:0]   iaddr;
    logic [CW-1:0] outst_nx;
    logic [1:0]    unused_bits;

    assign unused_bits = bus.jump_addr_i[1:0];

    assign jump     = bus.jump_flag_i;
    assign req      = (state != BOOT) && (({1'b0, cnt} + {1'b0, outst}) < CAP);
    assign gnt      = req & bus.ibus_gnt_i;
    // rvalid with nothing outstanding is a stray and must not touch counters
    assign rv       = bus.ibus_rvalid_i & (outst != '0);
    assign keep     = rv & (discard == '0) & ~jump;
    assign head_vld = (cnt != '0);
    assign outst_nx = outst + CW'(gnt) - CW'(rv);

`ifdef IFU_BYPASS_EN
    logic byp;
    assign byp   = keep & ~head_vld;
    assign valid = (head_vld & ~jump) | byp;
    assign push  = keep & ~(byp & bus.inst_ready_i);
    assign inst  = head_vld ? data_q[rd_ptr] : bus.ibus_rdata_i;
    assign iaddr = head_vld ? addr_q[rd_ptr] : tag_q[t_rd];
`else
    assign valid = head_vld & ~jump;
    assign push  = keep;
    assign inst  = data_q[rd_ptr];
    assign iaddr = addr_q[rd_ptr];
`endif

    assign pop = valid & bus.inst_ready_i & head_vld;

    assign bus.ibus_req_o   = req;
    assign bus.ibus_addr_o  = fetch_pc;
    assign bus.inst_valid_o = valid;
    assign bus.inst_o       = valid ? inst : NOP_INST;
    assign bus.inst_addr_o  = valid ? iaddr : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
            cnt      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            t_rd     <= '0;
            t_wr     <= '0;
        end else begin
            outst <= outst_nx;
            if (jump) begin
                // everything still in flight, incl. this cycle's grant, is wrong-path
                fetch_pc <= {bus.jump_addr_i[31:2], 2'b00};
                discard  <= outst_nx;
                cnt      <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                t_rd     <= '0;
                t_wr     <= '0;
                state    <= (outst_nx != '0) ? DRAIN : RUN;
            end else begin
                if (gnt) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    t_wr     <= t_wr + PW'(1);
                end
                if (rv && discard != '0) discard <= discard - CW'(1);
                if (keep) t_rd <= t_rd + PW'(1);
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                cnt <= cnt + CW'(push) - CW'(pop);
                unique case (state)
                    BOOT:    state <= RUN;
                    DRAIN:   if (rv && discard == CW'(1)) state <= RUN;
                    default: state <= state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt && !jump) tag_q[t_wr] <= fetch_pc;
        if (push) begin
            data_q[wr_ptr] <= bus.ibus_rdata_i;
            addr_q[wr_ptr] <= tag_q[t_rd];
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: random bus / IF-ID stimulus against a queue model of fetch;
// a monitor pops expected {addr, inst} pairs as the DUT presents them.
`timescale 1ns/1ps
module tb_ifu_prefetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct { logic [31:0] addr; bit wrong; int due; } fl_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ifu_prefetch_if bus();

    ifu_prefetch #(
        .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    fl_t         infl[$];
    ex_t         expq[$];
    logic [31:0] pc;
    bit          boot;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          gnt_pct, rv_pct, rdy_pct, lat_min, lat_max;
    int          pushed_now = 0;
    bit          mon_en = 0;
    int          first_valid = -1;
    int          rel_cyc = 0;
    int          grants = 0;
    bit          jmp_mark = 0;
    logic [31:0] first_after_jump = 32'hdead_beef;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic knobs(input int g, input int r, input int d, input int lmin, input int lmax);
        gnt_pct = g; rv_pct = r; rdy_pct = d; lat_min = lmin; lat_max = lmax;
    endtask

    // one clock: called at a negedge, drives inputs, advances the model, returns at next negedge
    task automatic step(input bit jmp, input logic [31:0] ja, input bit stray);
        bit  er, g, r;
        fl_t e;
        int  lat;
        er = !boot && (expq.size() + infl.size() < DEPTH);
        chk("req", {31'b0, bus.ibus_req_o}, {31'b0, er});
        if (er) chk("ibus_addr", bus.ibus_addr_o, pc);
        g = er && ($urandom_range(99) < gnt_pct);
        r = infl.size() > 0 && cyc >= infl[0].due && ($urandom_range(99) < rv_pct);
        bus.ibus_gnt_i    = g;
        bus.ibus_rvalid_i = r || (stray && infl.size() == 0);
        bus.ibus_rdata_i  = r ? mem(infl[0].addr) : $urandom;
        bus.inst_ready_i  = ($urandom_range(99) < rdy_pct);
        bus.jump_flag_i   = jmp;
        bus.jump_addr_i   = ja;
        pushed_now = 0;
        if (r) begin
            e = infl.pop_front();
            if (!e.wrong && !jmp) begin
                expq.push_back('{e.addr, mem(e.addr)});
                pushed_now = 1;
            end
        end
        if (g) begin
            lat = $urandom_range(lat_max, lat_min);
            infl.push_back('{pc, jmp, cyc + lat});
            pc += 32'd4;
            grants++;
        end
        if (jmp) begin
            foreach (infl[i]) infl[i].wrong = 1'b1;
            expq.delete();
            pc = {ja[31:2], 2'b00};
            jmp_mark = 1'b1;
        end
        @(posedge clk);
        cyc++;
        boot = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit check_out);
        mon_en = 1'b0;
        #1 rst = 1'b0;
        bus.ibus_gnt_i = 0; bus.ibus_rvalid_i = 0; bus.ibus_rdata_i = 0;
        bus.jump_flag_i = 0; bus.jump_addr_i = 0; bus.inst_ready_i = 0;
        #1;
        if (check_out) begin
            chk("rst_req", {31'b0, bus.ibus_req_o}, 32'h0);
            chk("rst_addr", bus.ibus_addr_o, RESET_PC);
            chk("rst_valid", {31'b0, bus.inst_valid_o}, 32'h0);
            chk("rst_inst", bus.inst_o, NOP);
            chk("rst_inst_addr", bus.inst_addr_o, 32'h0);
        end
        infl.delete(); expq.delete();
        pc = RESET_PC; boot = 1'b1; pushed_now = 0; jmp_mark = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rel_cyc = cyc; first_valid = -1; mon_en = 1'b1;
    endtask

    initial begin : monitor
        bit ev;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
`ifdef IFU_BYPASS_EN
                ev = expq.size() > 0 && !bus.jump_flag_i;
`else
                ev = (expq.size() - pushed_now) > 0 && !bus.jump_flag_i;
`endif
                chk("inst_valid", {31'b0, bus.inst_valid_o}, {31'b0, ev});
                if (bus.inst_valid_o) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (expq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_inst: got addr %h want none", bus.inst_addr_o);
                    end else begin
                        chk("inst", bus.inst_o, expq[0].data);
                        chk("inst_addr", bus.inst_addr_o, expq[0].addr);
                        if (bus.inst_ready_i) begin
                            if (jmp_mark) begin
                                first_after_jump = expq[0].addr;
                                jmp_mark = 1'b0;
                            end
                            void'(expq.pop_front());
                        end
                    end
                end else begin
                    chk("nop", bus.inst_o, NOP);
                end
            end
        end
    end

    initial begin : timeout
        #400000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit done;
        bit wrapped;
        @(negedge clk);

        // reset release: immediate grant, 1-cycle response
        do_reset(1'b1);
        knobs(100, 100, 100, 1, 1);
        repeat (10) step(1'b0, 32'h0, 1'b0);
`ifdef IFU_BYPASS_EN
        chk("first_latency", first_valid - rel_cyc, 32'd2);
`else
        chk("first_latency", first_valid - rel_cyc, 32'd3);
`endif

        // hold: IF/ID stalled, only DEPTH requests may be granted
        do_reset(1'b0);
        knobs(100, 100, 0, 1, 1);
        grants = 0;
        repeat (10) step(1'b0, 32'h0, 1'b0);
        chk("hold_grants", grants, DEPTH);
        chk("hold_head", bus.inst_addr_o, 32'h0);
        knobs(100, 100, 100, 1, 1);
        repeat (8) step(1'b0, 32'h0, 1'b0);

        // jump with one outstanding plus a grant in the jump cycle
        do_reset(1'b0);
        knobs(100, 100, 100, 4, 4);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!boot && infl.size() == 1 && expq.size() == 0) begin
                step(1'b1, 32'h8000_0102, 1'b0);
                done = 1'b1;
            end else begin
                step(1'b0, 32'h0, 1'b0);
            end
        end
        chk("jump_setup", {31'b0, done}, 32'h1);
        chk("jump_target", bus.ibus_addr_o, 32'h8000_0100);
        knobs(100, 100, 100, 1, 1);
        repeat (16) step(1'b0, 32'h0, 1'b0);
        chk("first_after_jump", first_after_jump, 32'h8000_0100);

        // PC wrap at the top of the address space
        step(1'b1, 32'hFFFF_FFFE, 1'b0);
        wrapped = 1'b0;
        for (int i = 0; i < 12 && !wrapped; i++) begin
            step(1'b0, 32'h0, 1'b0);
            if (pc == 32'h0) wrapped = 1'b1;
        end
        chk("wrap_seen", {31'b0, wrapped}, 32'h1);
        chk("wrap_addr", bus.ibus_addr_o, 32'h0);
        repeat (8) step(1'b0, 32'h0, 1'b0);

        // asynchronous reset with two responses in flight, then stray rvalids
        knobs(100, 100, 100, 3, 3);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (infl.size() == DEPTH) done = 1'b1;
            else step(1'b0, 32'h0, 1'b0);
        end
        chk("midreset_setup", {31'b0, done}, 32'h1);
        do_reset(1'b1);
        knobs(100, 100, 100, 2, 2);
        repeat (4) step(1'b0, 32'h0, 1'b1);
        repeat (16) step(1'b0, 32'h0, 1'b0);

        // random traffic with random redirects
        do_reset(1'b0);
        knobs(70, 80, 70, 1, 4);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 5) begin
                if ($urandom_range(3) == 0) step(1'b1, 32'hFFFF_FFF0 | 32'($urandom_range(15)), 1'b0);
                else step(1'b1, $urandom, 1'b0);
            end else begin
                step(1'b0, 32'h0, 1'b0);
            end
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
